// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, load/store and RAM-side signals of the memory arbiter.
// The arbiter uses the slave modport; requesters and the RAM model use master.
interface mem_arbiter_if;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_abort;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    modport slave (
        input  rdy, if_req, if_addr, if_abort, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
               ram_din,
        output if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
    );

    modport master (
        output rdy, if_req, if_addr, if_abort, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
               ram_din,
        input  if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: shares one 8-bit RAM port between instruction
// fetch (word reads) and load/store (1/2/4 bytes). Loads have priority.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StIfRd, StMemRd, StMemWr, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] res_q, res_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        is_mem_q, is_mem_d;

    logic [2:0]  mem_n;
    logic [2:0]  cap_idx;
    logic [31:0] res_ins;
    logic        busy;
    logic        in_range;

    // Registers for FSM, transfer context and result words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            base_q      <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            res_q       <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            is_mem_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            res_q       <= res_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            is_mem_q    <= is_mem_d;
        end
    end

    // Decode byte count and merge the incoming RAM byte into the result.
    always_comb begin
        mem_n   = bus.mem_len[1] ? 3'd4 : (bus.mem_len[0] ? 3'd2 : 3'd1);
        // ram_din belongs to the address issued one cycle earlier, i.e. byte cnt-1
        cap_idx = cnt_q - 3'd1;
        res_ins = res_q;
        res_ins[{cap_idx[1:0], 3'b000} +: 8] = bus.ram_din;
    end

    // Next-state logic; everything holds while rdy is low.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        res_d       = res_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        is_mem_d    = is_mem_q;
        if (bus.rdy) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.mem_req) begin
                        state_d  = bus.mem_we ? StMemWr : StMemRd;
                        base_d   = bus.mem_addr;
                        len_d    = mem_n;
                        wdata_d  = bus.mem_wdata;
                        res_d    = '0;
                        cnt_d    = '0;
                        is_mem_d = 1'b1;
                    end else if (bus.if_req) begin
                        state_d  = StIfRd;
                        base_d   = bus.if_addr;
                        len_d    = 3'd4;
                        wdata_d  = '0;
                        res_d    = '0;
                        cnt_d    = '0;
                        is_mem_d = 1'b0;
                    end
                end
                StIfRd, StMemRd: begin
                    if (state_q == StIfRd && bus.if_abort) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q != 3'd0) res_d = res_ins;
                        if (cnt_q == len_q) begin
                            state_d = StDone;
                            if (is_mem_q) mem_rdata_d = res_ins;
                            else          if_data_d   = res_ins;
                        end
                    end
                end
                StMemWr: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == len_q - 3'd1) state_d = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // RAM port and completion outputs, decoded from the current state.
    always_comb begin
        busy     = (state_q == StIfRd) || (state_q == StMemRd) || (state_q == StMemWr);
        in_range = cnt_q < len_q;
        bus.ram_a    = (busy && in_range) ? base_q + {29'd0, cnt_q} : '0;
        bus.ram_wr   = (state_q == StMemWr) && in_range && bus.rdy;
        bus.ram_dout = ((state_q == StMemWr) && in_range) ?
                       wdata_q[{cnt_q[1:0], 3'b000} +: 8] : '0;
        // Gated by rdy so a frozen DONE cycle does not stretch the pulse
        bus.if_done   = (state_q == StDone) && !is_mem_q && bus.rdy;
        bus.mem_done  = (state_q == StDone) && is_mem_q && bus.rdy;
        bus.if_data   = if_data_q;
        bus.mem_rdata = mem_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide RAM model (one-cycle read).
module tb_mem_arbiter;
    logic clk;
    logic rst_n;
    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] ram [logic [31:0]];
    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // RAM model: read data reflects the previous cycle's address.
    always @(posedge clk) begin
        bus.ram_din <= rd(bus.ram_a);
        if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input bit want_mem, input int limit);
        bit found = 1'b0;
        bit stray = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            tick();
            if (want_mem ? bus.mem_done : bus.if_done) found = 1'b1;
            if (want_mem ? bus.if_done : bus.mem_done) stray = 1'b1;
        end
        check({tag, "_done"}, 32'(found), 32'd1);
        check({tag, "_stray"}, 32'(stray), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rdy = 1'b1;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.if_abort = 1'b0;
        bus.mem_req = 1'b0;
        bus.mem_we = 1'b0;
        bus.mem_len = 2'b00;
        bus.mem_addr = '0;
        bus.mem_wdata = '0;
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ram[32'h200] = 8'hAB;
        ram[32'h204] = 8'h01; ram[32'h205] = 8'h02; ram[32'h206] = 8'h03; ram[32'h207] = 8'h04;
        ram[32'h300] = 8'h55; ram[32'h301] = 8'h66; ram[32'h302] = 8'h77; ram[32'h303] = 8'h88;

        // Reset state
        #12;
        check("rst_ram_a", bus.ram_a, 32'h0);
        check("rst_ram_wr", 32'(bus.ram_wr), 32'h0);
        check("rst_done", {30'd0, bus.if_done, bus.mem_done}, 32'h0);
        check("rst_if_data", bus.if_data, 32'h0);
        #5 rst_n = 1'b1;
        tick();

        // Word fetch: bytes on consecutive cycles, done after edge 5
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        tick(); check("fetch_a0", bus.ram_a, 32'h100);
        tick(); check("fetch_a1", bus.ram_a, 32'h101);
        tick(); check("fetch_a2", bus.ram_a, 32'h102);
        tick(); check("fetch_a3", bus.ram_a, 32'h103);
        tick(); check("fetch_a_end", bus.ram_a, 32'h0);
        check("fetch_early_done", 32'(bus.if_done), 32'h0);
        tick(); check("fetch_done", 32'(bus.if_done), 32'h1);
        check("fetch_data", bus.if_data, 32'h44332211);
        bus.if_req = 1'b0;
        tick(); check("fetch_done_pulse", 32'(bus.if_done), 32'h0);

        // Contention: byte load wins, fetch follows
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'b00; bus.mem_addr = 32'h200;
        tick(); check("cont_grant_a", bus.ram_a, 32'h200);
        tick(); check("cont_a_end", bus.ram_a, 32'h0);
        tick(); check("cont_mem_done", 32'(bus.mem_done), 32'h1);
        check("cont_if_done", 32'(bus.if_done), 32'h0);
        check("cont_rdata", bus.mem_rdata, 32'h000000AB);
        bus.mem_req = 1'b0;
        tick(); check("cont_idle_a", bus.ram_a, 32'h0);
        check("cont_idle_done", 32'(bus.mem_done), 32'h0);
        tick(); check("cont_fetch_a", bus.ram_a, 32'h100);
        wait_done("cont_fetch", 1'b0, 8);
        check("cont_fetch_data", bus.if_data, 32'h44332211);
        bus.if_req = 1'b0;
        tick();

        // Half store wrapping past the top of the address space
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'b01;
        bus.mem_addr = 32'hFFFFFFFF; bus.mem_wdata = 32'hDEADBEEF;
        tick(); check("hs_a0", bus.ram_a, 32'hFFFFFFFF);
        check("hs_wr0", {23'd0, bus.ram_wr, bus.ram_dout}, 32'h1EF);
        tick(); check("hs_a1", bus.ram_a, 32'h0);
        check("hs_wr1", {23'd0, bus.ram_wr, bus.ram_dout}, 32'h1BE);
        tick(); check("hs_done", 32'(bus.mem_done), 32'h1);
        check("hs_wr_off", 32'(bus.ram_wr), 32'h0);
        bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        check("hs_ram", {16'd0, rd(32'hFFFFFFFF), rd(32'h0)}, 32'h0000EFBE);
        tick();

        // Abort at cnt = 2, pending word load then granted
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        tick(); tick(); tick();
        check("ab_a2", bus.ram_a, 32'h302);
        bus.if_abort = 1'b1; bus.if_req = 1'b0;
        bus.mem_req = 1'b1; bus.mem_len = 2'b10; bus.mem_addr = 32'h204;
        tick(); check("ab_idle_a", bus.ram_a, 32'h0);
        check("ab_no_done", 32'(bus.if_done), 32'h0);
        check("ab_if_data", bus.if_data, 32'h44332211);
        bus.if_abort = 1'b0;
        tick(); check("ab_mem_grant", bus.ram_a, 32'h204);
        wait_done("ab_load", 1'b1, 8);
        check("ab_rdata", bus.mem_rdata, 32'h04030201);
        bus.mem_req = 1'b0;
        tick();

        // Freeze: three rdy-low cycles in the middle of a word store
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'b10;
        bus.mem_addr = 32'h400; bus.mem_wdata = 32'hCAFEF00D;
        tick(); check("fz_wr0", {bus.ram_a[15:0], 7'd0, bus.ram_wr, bus.ram_dout}, 32'h0400010D);
        tick(); check("fz_wr1", {bus.ram_a[15:0], 7'd0, bus.ram_wr, bus.ram_dout}, 32'h040101F0);
        bus.rdy = 1'b0;
        #1;
        check("fz_wr_forced", 32'(bus.ram_wr), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fz_hold", {bus.ram_a[15:0], 6'd0, bus.ram_wr, bus.mem_done, 8'd0}, 32'h04010000);
        end
        bus.rdy = 1'b1;
        #1;
        check("fz_resume", {bus.ram_a[15:0], 7'd0, bus.ram_wr, bus.ram_dout}, 32'h040101F0);
        tick(); check("fz_a2", bus.ram_a, 32'h402);
        tick(); check("fz_a3", bus.ram_a, 32'h403);
        check("fz_not_yet", 32'(bus.mem_done), 32'h0);
        tick(); check("fz_done", 32'(bus.mem_done), 32'h1);
        bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        check("fz_ram", {rd(32'h403), rd(32'h402), rd(32'h401), rd(32'h400)}, 32'hCAFEF00D);
        tick();

        // Asynchronous reset in the middle of a load
        bus.mem_req = 1'b1; bus.mem_len = 2'b10; bus.mem_addr = 32'h204;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("ar_ram_a", bus.ram_a, 32'h0);
        check("ar_ram_wr_dout", {23'd0, bus.ram_wr, bus.ram_dout}, 32'h0);
        check("ar_if_data", bus.if_data, 32'h0);
        check("ar_mem_rdata", bus.mem_rdata, 32'h0);
        check("ar_done", {30'd0, bus.if_done, bus.mem_done}, 32'h0);
        bus.mem_req = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        wait_done("ar_fetch", 1'b0, 8);
        check("ar_fetch_data", bus.if_data, 32'h44332211);
        bus.if_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed below.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: rdy  input  1  global ready; low freezes the block.
REQ-005 SHALL have port: if_req  input  1  instruction-fetch read request; word (4-byte) read.
REQ-006 SHALL have port: if_addr  input  32  fetch byte address.
REQ-007 SHALL have port: if_abort  input  1  cancels an in-flight fetch (branch/jump redirect).
REQ-008 SHALL have port: if_done  output  1  one-cycle pulse; if_data valid.
REQ-009 SHALL have port: if_data  output  32  fetched word, little-endian.
REQ-010 SHALL have port: mem_req  input  1  load/store request.
REQ-011 SHALL have port: mem_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port: mem_len  input  2  00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes.
REQ-013 SHALL have port: mem_addr  input  32  load/store base byte address.
REQ-014 SHALL have port: mem_wdata  input  32  store data; byte i is bits [8i+7:8i].
REQ-015 SHALL have port: mem_done  output  1  one-cycle pulse; load data valid or store complete.
REQ-016 SHALL have port: mem_rdata  output  32  load result; unused upper bytes zero.
REQ-017 SHALL have port: ram_din  input  8  RAM read byte; reflects address of previous cycle.
REQ-018 SHALL have port: ram_dout  output  8  RAM write byte.
REQ-019 SHALL have port: ram_a  output  32  RAM byte address.
REQ-020 SHALL have port: ram_wr  output  1  RAM write enable, 1 = write.

Function
REQ-021 SHALL implement states IDLE, IF_RD, MEM_RD, MEM_WR, DONE, plus a 3-bit byte counter cnt and registered base address, length N, and write data.
REQ-022 SHALL sample requests only in IDLE; mem_req has priority over if_req when both are high; grant latches addr/len/we/wdata at that edge, with cnt = 0.
REQ-023 SHALL require requesters to hold req and payload stable until their done pulse and to drop req in the done cycle; a req still high in the cycle after done is a new request.
REQ-024 SHALL drive, in any busy state with cnt < N: ram_a = base + cnt (mod 2^32 wrap); otherwise ram_a = 0.
REQ-025 SHALL in read states capture ram_din into byte (cnt-1) of the result at each edge where 1 <= cnt <= N; cnt increments every active edge; at the edge where cnt = N, enter DONE.
REQ-026 SHALL in MEM_WR assert ram_wr = 1 with ram_dout = wdata byte cnt while cnt < N; at the edge where cnt = N-1, enter DONE; ram_wr = 0 and ram_dout = 0 in all other states.
REQ-027 SHALL in DONE assert exactly one of if_done or mem_done for one cycle, then return to IDLE at the next edge.
REQ-028 SHALL give the following latency, counted in edges after the grant edge: reads pulse done after edge N+1 (word fetch: after edge 5); writes after edge N (word store: after edge 4).
REQ-029 SHALL zero the result register at grant, so a 1- or 2-byte load returns zero upper bytes.
REQ-030 SHALL hold if_data and mem_rdata stable until the next done of the same port.
REQ-031 SHALL on if_abort high at an active edge in IF_RD go to IDLE without if_done; if_data is unchanged.
REQ-032 SHALL ignore if_abort in IDLE, DONE, MEM_RD and MEM_WR; stores are never aborted.
REQ-033 SHALL when rdy = 0 hold all state, counters and result registers, and force ram_wr = 0; the transfer resumes unchanged when rdy returns to 1.

Reset
REQ-034 SHALL on rst_n low, immediately and independent of clk, force: state IDLE, cnt 0, registered base/len/wdata 0, if_data 0, mem_rdata 0, if_done 0, mem_done 0, ram_wr 0, ram_a 0, ram_dout 0.
REQ-035 SHALL abandon any in-flight transfer on reset with no done pulse; the first request is sampled at the first rising edge after rst_n rises.

Verification
REQ-036 SHALL pass word fetch: if_req, if_addr = 0x100, RAM bytes 11,22,33,44 -> ram_a 0x100..0x103 on consecutive cycles, if_done after edge 5, if_data = 0x44332211.
REQ-037 SHALL pass contention: if_req and mem_req (load, mem_len = 00, addr 0x200 = 0xAB) rise together -> MEM_RD granted first, mem_rdata = 0x000000AB; fetch then starts in the cycle after mem_done.
REQ-038 SHALL pass half store: mem_we = 1, mem_len = 01, addr 0xFFFFFFFF, wdata 0xDEADBEEF -> writes EF at 0xFFFFFFFF, then BE at 0x00000000; mem_done after edge 2.
REQ-039 SHALL pass abort: if_abort pulsed with cnt = 2 during a fetch -> IDLE next edge, no if_done, if_data unchanged, and a pending mem_req is granted next.
REQ-040 SHALL pass freeze: rdy low for 3 cycles mid word-store -> ram_wr = 0 and ram_a unchanged during the freeze; the remaining bytes are written after resume with done delayed by exactly 3 cycles.
REQ-041 SHALL pass reset: rst_n low mid-load -> all outputs 0 asynchronously; a new request after release completes normally.
